// File: rtl/dbus_arbiter.sv
// dbus_arbiter
// Shares the single DCache data-bus port between two load lanes and the
// write-buffer drain. Only one transaction is in flight at a time. Its
// response is routed back to whichever source issued it.
//
// Ports
//   clk, reset                     clock and synchronous active-high reset
//   rd_valid/rd_ready [1:0]        per-lane load handshake
//   rd_addr [127:0]                lane addresses, lane i at [64*i +: 64]
//   rd_msize [5:0]                 lane size codes, lane i at [3*i +: 3]
//   rd_dst [2*PREG_W-1:0]          lane destination tags, lane i at [PREG_W*i +: PREG_W]
//   rd_resp_valid/data/dst         load response pulse, raw dword and tag
//   wb_valid/wb_full/wb_ready      write-buffer drain handshake and full flag
//   wb_addr/wb_data/wb_strobe      drain entry at the write-buffer head
//   wb_ack                         drain completion pulse
//   dreq_*                         request to the DCache
//   dresp_addr_ok/data_ok/data     DCache accept, completion and load data
module dbus_arbiter #(
    parameter int PREG_W     = 7,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            rd_valid,
    output logic [1:0]            rd_ready,
    input  logic [127:0]          rd_addr,
    input  logic [5:0]            rd_msize,
    input  logic [2*PREG_W-1:0]   rd_dst,
    output logic [1:0]            rd_resp_valid,
    output logic [63:0]           rd_resp_data,
    output logic [PREG_W-1:0]     rd_resp_dst,
    input  logic                  wb_valid,
    input  logic                  wb_full,
    output logic                  wb_ready,
    input  logic [63:0]           wb_addr,
    input  logic [63:0]           wb_data,
    input  logic [7:0]            wb_strobe,
    output logic                  wb_ack,
    output logic                  dreq_valid,
    output logic                  dreq_write,
    output logic [63:0]           dreq_addr,
    output logic [63:0]           dreq_data,
    output logic [7:0]            dreq_strobe,
    output logic [2:0]            dreq_size,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [63:0]           dresp_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [63:0]         addr_q, addr_d;
    logic [63:0]         data_q, data_d;
    logic [7:0]          strobe_q, strobe_d;
    logic [2:0]          size_q, size_d;
    logic [PREG_W-1:0]   dst_q, dst_d;
    logic                write_q, write_d;
    logic                lane_q, lane_d;

    logic                starve_hit;
    logic                load_go;
    logic                load_lane;
    logic                complete;

    // State and latched transaction fields. Reset drops any in-flight
    // transaction; its response is never reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            strobe_q     <= '0;
            size_q       <= '0;
            dst_q        <= '0;
            write_q      <= 1'b0;
            lane_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strobe_q     <= strobe_d;
            size_q       <= size_d;
            dst_q        <= dst_d;
            write_q      <= write_d;
            lane_q       <= lane_d;
        end
    end

    // Arbitration in IDLE, request presentation in REQ, completion routing
    // in REQ (combined addr_ok/data_ok) or WAIT. Everything is suppressed
    // while reset is high so an abort never leaks a response pulse.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        starve_cnt_d  = starve_cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        strobe_d      = strobe_q;
        size_d        = size_q;
        dst_d         = dst_q;
        write_d       = write_q;
        lane_d        = lane_q;
        rd_ready      = 2'b00;
        rd_resp_valid = 2'b00;
        rd_resp_data  = '0;
        rd_resp_dst   = '0;
        wb_ready      = 1'b0;
        wb_ack        = 1'b0;
        dreq_valid    = 1'b0;
        dreq_write    = 1'b0;
        dreq_addr     = '0;
        dreq_data     = '0;
        dreq_strobe   = '0;
        dreq_size     = '0;
        complete      = 1'b0;
        load_go       = 1'b0;
        load_lane     = rr_q;

        starve_hit = (starve_cnt_q == CNT_MAX);

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    // Forced drain outranks loads; the RR lane is tried before the other lane.
                    if (wb_valid && (wb_full || starve_hit)) begin
                        wb_ready = 1'b1;
                    end else if (rd_valid[rr_q]) begin
                        load_go   = 1'b1;
                        load_lane = rr_q;
                    end else if (rd_valid[~rr_q]) begin
                        load_go   = 1'b1;
                        load_lane = ~rr_q;
                    end else if (wb_valid) begin
                        wb_ready = 1'b1;
                    end

                    if (load_go) begin
                        rd_ready[load_lane] = 1'b1;
                        addr_d   = rd_addr[64*load_lane +: 64];
                        data_d   = '0;
                        strobe_d = '0;
                        size_d   = rd_msize[3*load_lane +: 3];
                        dst_d    = rd_dst[PREG_W*load_lane +: PREG_W];
                        write_d  = 1'b0;
                        lane_d   = load_lane;
                        rr_d     = ~load_lane;
                        if (wb_valid && !starve_hit) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                        state_d = REQ;
                    end else if (wb_ready) begin
                        addr_d       = wb_addr;
                        data_d       = wb_data;
                        strobe_d     = wb_strobe;
                        size_d       = 3'd3;
                        dst_d        = '0;
                        write_d      = 1'b1;
                        starve_cnt_d = '0;
                        state_d      = REQ;
                    end
                end
                REQ: begin
                    dreq_valid  = 1'b1;
                    dreq_write  = write_q;
                    dreq_addr   = addr_q;
                    dreq_data   = data_q;
                    dreq_strobe = strobe_q;
                    dreq_size   = size_q;
                    if (dresp_addr_ok) begin
                        if (dresp_data_ok) begin
                            complete = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dresp_data_ok) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (complete) begin
                if (write_q) begin
                    wb_ack = 1'b1;
                end else begin
                    rd_resp_valid[lane_q] = 1'b1;
                    rd_resp_data          = dresp_data;
                    rd_resp_dst           = dst_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter
// Directed self-checking bench for dbus_arbiter. The bench plays the DCache
// and both requester sides by hand; expected values are written out in each step.
module tb_dbus_arbiter;

    localparam int PREG_W     = 7;
    localparam int STARVE_MAX = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            rd_valid;
    logic [1:0]            rd_ready;
    logic [127:0]          rd_addr;
    logic [5:0]            rd_msize;
    logic [2*PREG_W-1:0]   rd_dst;
    logic [1:0]            rd_resp_valid;
    logic [63:0]           rd_resp_data;
    logic [PREG_W-1:0]     rd_resp_dst;
    logic                  wb_valid;
    logic                  wb_full;
    logic                  wb_ready;
    logic [63:0]           wb_addr;
    logic [63:0]           wb_data;
    logic [7:0]            wb_strobe;
    logic                  wb_ack;
    logic                  dreq_valid;
    logic                  dreq_write;
    logic [63:0]           dreq_addr;
    logic [63:0]           dreq_data;
    logic [7:0]            dreq_strobe;
    logic [2:0]            dreq_size;
    logic                  dresp_addr_ok;
    logic                  dresp_data_ok;
    logic [63:0]           dresp_data;

    int errors = 0;
    int checks = 0;

    dbus_arbiter #(.PREG_W(PREG_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_msize(rd_msize), .rd_dst(rd_dst),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_dst(rd_resp_dst),
        .wb_valid(wb_valid), .wb_full(wb_full), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_strobe(wb_strobe), .wb_ack(wb_ack),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_data(dreq_data), .dreq_strobe(dreq_strobe), .dreq_size(dreq_size),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Moves just past the next rising edge so inputs change away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one load lane's request fields.
    task automatic applyStimulus(input int lane, input logic v, input logic [63:0] a,
                                 input logic [PREG_W-1:0] d, input logic [2:0] sz);
        rd_valid[lane]                 = v;
        rd_addr[64*lane +: 64]         = a;
        rd_dst[PREG_W*lane +: PREG_W]  = d;
        rd_msize[3*lane +: 3]          = sz;
    endtask

    // Starting in IDLE with inputs settled: expect a grant to 'lane', then
    // accept the request and return 'data' one cycle later.
    task automatic runLoad(input string tag, input int lane, input logic [63:0] addr,
                           input logic [PREG_W-1:0] dst, input logic [2:0] sz,
                           input logic [63:0] data);
        checkOutput({tag, " rd_ready"}, 64'(rd_ready), 64'(1) << lane);
        checkOutput({tag, " wb_ready"}, 64'(wb_ready), 64'(0));
        tick();
        dresp_addr_ok = 1'b1;
        #1;
        checkOutput({tag, " dreq_valid"}, 64'(dreq_valid), 64'(1));
        checkOutput({tag, " dreq_write"}, 64'(dreq_write), 64'(0));
        checkOutput({tag, " dreq_addr"}, dreq_addr, addr);
        checkOutput({tag, " dreq_size"}, 64'(dreq_size), 64'(sz));
        checkOutput({tag, " dreq_strobe"}, 64'(dreq_strobe), 64'(0));
        checkOutput({tag, " rd_ready in REQ"}, 64'(rd_ready), 64'(0));
        tick();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = data;
        #1;
        checkOutput({tag, " dreq_valid in WAIT"}, 64'(dreq_valid), 64'(0));
        checkOutput({tag, " rd_resp_valid"}, 64'(rd_resp_valid), 64'(1) << lane);
        checkOutput({tag, " rd_resp_data"}, rd_resp_data, data);
        checkOutput({tag, " rd_resp_dst"}, 64'(rd_resp_dst), 64'(dst));
        checkOutput({tag, " wb_ack"}, 64'(wb_ack), 64'(0));
        tick();
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        #1;
    endtask

    // Starting in IDLE with inputs settled: expect a drain grant, hold
    // addr_ok low for 'stall' cycles, then complete. The drain inputs are
    // scrambled after the grant so only the latched copy can reach dreq_*.
    task automatic runDrain(input string tag, input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int stall);
        checkOutput({tag, " wb_ready"}, 64'(wb_ready), 64'(1));
        checkOutput({tag, " rd_ready"}, 64'(rd_ready), 64'(0));
        tick();
        wb_addr   = ~addr;
        wb_data   = ~data;
        wb_strobe = ~strb;
        for (int i = 0; i <= stall; i++) begin
            dresp_addr_ok = (i == stall);
            #1;
            checkOutput({tag, " dreq_valid"}, 64'(dreq_valid), 64'(1));
            checkOutput({tag, " dreq_write"}, 64'(dreq_write), 64'(1));
            checkOutput({tag, " dreq_addr"}, dreq_addr, addr);
            checkOutput({tag, " dreq_data"}, dreq_data, data);
            checkOutput({tag, " dreq_strobe"}, 64'(dreq_strobe), 64'(strb));
            checkOutput({tag, " dreq_size"}, 64'(dreq_size), 64'(3));
            if (i < stall) tick();
        end
        tick();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b1;
        #1;
        checkOutput({tag, " wb_ack"}, 64'(wb_ack), 64'(1));
        checkOutput({tag, " rd_resp_valid"}, 64'(rd_resp_valid), 64'(0));
        checkOutput({tag, " dreq_valid in WAIT"}, 64'(dreq_valid), 64'(0));
        tick();
        dresp_data_ok = 1'b0;
        #1;
        checkOutput({tag, " wb_ack after"}, 64'(wb_ack), 64'(0));
    endtask

    // Directed sequence: reset, round-robin, starvation, full flag, stall,
    // combined addr_ok/data_ok, reset during WAIT.
    initial begin
        reset         = 1'b1;
        rd_valid      = '0;
        rd_addr       = '0;
        rd_msize      = '0;
        rd_dst        = '0;
        wb_valid      = 1'b0;
        wb_full       = 1'b0;
        wb_addr       = '0;
        wb_data       = '0;
        wb_strobe     = '0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("reset rd_ready", 64'(rd_ready), 64'(0));
        checkOutput("reset wb_ready", 64'(wb_ready), 64'(0));
        checkOutput("reset dreq_valid", 64'(dreq_valid), 64'(0));
        checkOutput("reset dreq_addr", dreq_addr, 64'(0));
        checkOutput("reset rd_resp_valid", 64'(rd_resp_valid), 64'(0));
        checkOutput("reset wb_ack", 64'(wb_ack), 64'(0));

        // Round-robin between two always-valid lanes.
        applyStimulus(0, 1'b1, 64'h0000_1000, 7'h05, 3'd3);
        applyStimulus(1, 1'b1, 64'h0000_2008, 7'h09, 3'd2);
        #1;
        runLoad("rr0", 0, 64'h0000_1000, 7'h05, 3'd3, 64'hAAAA_0000_0000_0001);
        applyStimulus(0, 1'b1, 64'h0000_1040, 7'h11, 3'd1);
        #1;
        runLoad("rr1", 1, 64'h0000_2008, 7'h09, 3'd2, 64'hBBBB_0000_0000_0002);
        runLoad("rr2", 0, 64'h0000_1040, 7'h11, 3'd1, 64'hCCCC_0000_0000_0003);

        // Starvation: eight load grants with a drain pending, then the drain.
        applyStimulus(1, 1'b0, 64'h0, 7'h00, 3'd0);
        applyStimulus(0, 1'b1, 64'h0000_3000, 7'h21, 3'd3);
        wb_valid  = 1'b1;
        wb_addr   = 64'h0000_9000;
        wb_data   = 64'h1122_3344_5566_7788;
        wb_strobe = 8'hF0;
        #1;
        for (int k = 0; k < STARVE_MAX; k++) begin
            runLoad($sformatf("starve%0d", k), 0, 64'h0000_3000, 7'h21, 3'd3, 64'(k));
            wb_addr   = 64'h0000_9000;
            wb_data   = 64'h1122_3344_5566_7788;
            wb_strobe = 8'hF0;
            #1;
        end
        runDrain("starve drain", 64'h0000_9000, 64'h1122_3344_5566_7788, 8'hF0, 0);
        // Counter cleared by the drain, so a load wins again.
        runLoad("post drain", 0, 64'h0000_3000, 7'h21, 3'd3, 64'h55);

        // Full write buffer beats two valid loads.
        applyStimulus(1, 1'b1, 64'h0000_4000, 7'h31, 3'd2);
        wb_full   = 1'b1;
        wb_addr   = 64'h0000_A000;
        wb_data   = 64'hDEAD_BEEF_0000_0001;
        wb_strobe = 8'h0F;
        #1;
        runDrain("full drain", 64'h0000_A000, 64'hDEAD_BEEF_0000_0001, 8'h0F, 0);

        // DCache stalls addr_ok for 5 cycles.
        wb_addr   = 64'h0000_B008;
        wb_data   = 64'hCAFE_F00D_1234_5678;
        wb_strobe = 8'h3C;
        #1;
        runDrain("stall drain", 64'h0000_B008, 64'hCAFE_F00D_1234_5678, 8'h3C, 5);

        // Lowest-priority drain when no load is waiting.
        wb_full  = 1'b0;
        rd_valid = 2'b00;
        wb_addr   = 64'h0000_C000;
        wb_data   = 64'h0F0F_0F0F_0F0F_0F0F;
        wb_strobe = 8'hFF;
        #1;
        runDrain("idle drain", 64'h0000_C000, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 1);
        wb_valid = 1'b0;

        // addr_ok and data_ok together.
        applyStimulus(0, 1'b1, 64'h8000_0010, 7'h42, 3'd3);
        #1;
        checkOutput("combo rd_ready", 64'(rd_ready), 64'(1));
        tick();
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0123_4567_89AB_CDEF;
        #1;
        checkOutput("combo dreq_addr", dreq_addr, 64'h8000_0010);
        checkOutput("combo rd_resp_valid", 64'(rd_resp_valid), 64'(1));
        checkOutput("combo rd_resp_data", rd_resp_data, 64'h0123_4567_89AB_CDEF);
        checkOutput("combo rd_resp_dst", 64'(rd_resp_dst), 64'(7'h42));
        tick();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        rd_valid      = 2'b00;
        #1;
        checkOutput("combo idle dreq_valid", 64'(dreq_valid), 64'(0));
        checkOutput("combo idle rd_resp_valid", 64'(rd_resp_valid), 64'(0));
        applyStimulus(1, 1'b1, 64'h0000_5000, 7'h51, 3'd3);
        #1;
        checkOutput("combo idle regrant", 64'(rd_ready), 64'(2));

        // Reset during WAIT aborts without a response.
        tick();
        rd_valid      = 2'b00;
        dresp_addr_ok = 1'b1;
        #1;
        checkOutput("abort dreq_valid", 64'(dreq_valid), 64'(1));
        tick();
        dresp_addr_ok = 1'b0;
        reset         = 1'b1;
        tick();
        reset         = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checkOutput("abort rd_resp_valid", 64'(rd_resp_valid), 64'(0));
        checkOutput("abort rd_resp_data", rd_resp_data, 64'(0));
        checkOutput("abort wb_ack", 64'(wb_ack), 64'(0));
        checkOutput("abort dreq_valid idle", 64'(dreq_valid), 64'(0));
        checkOutput("abort rd_ready", 64'(rd_ready), 64'(0));
        tick();
        dresp_data_ok = 1'b0;
        rd_valid      = 2'b11;
        #1;
        checkOutput("abort rr lane0", 64'(rd_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
